// File: rtl/sha1_msg_ctrl.sv
// sha1_msg_ctrl
//   Feeds a word-oriented SHA-1 core with one message at a time. It passes the
//   message words through, inserts the 0x80 pad byte and the zero fill, appends
//   the 64-bit big-endian bit length, waits for the last block to be compressed
//   and then registers the chaining values as the digest.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   message word handshake; a word moves when both are high
//   in_word             message word, big-endian (byte 0 = bits 31:24)
//   in_last, in_bytes   final word flag; valid bytes in final word (0 means 4)
//   core_nrst           active-low core reset, low for one cycle per message
//   core_wr, core_in    word write strobe and data to the core
//   core_busy           core is compressing, no writes accepted
//   core_h0..core_h4    core chaining values
//   digest              {h0,h1,h2,h3,h4}, held until the next message completes
//   digest_valid        one-cycle pulse when digest is updated
//   o_dbg_state         current FSM state for observation
//
// Handshake: in_valid may be raised at any time and the word must be held until
// the cycle where in_valid & in_ready is seen at a rising edge. in_ready is only
// ever high in DATA and never while core_busy is high, so an accepted word is
// always written to the core in the same cycle.
module sha1_msg_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_word,
  input  logic         in_last,
  input  logic [1:0]   in_bytes,
  output logic         core_nrst,
  output logic         core_wr,
  output logic [31:0]  core_in,
  input  logic         core_busy,
  input  logic [31:0]  core_h0,
  input  logic [31:0]  core_h1,
  input  logic [31:0]  core_h2,
  input  logic [31:0]  core_h3,
  input  logic [31:0]  core_h4,
  output logic [159:0] digest,
  output logic         digest_valid,
  output logic [3:0]   o_dbg_state
);

  typedef enum logic [3:0] {
    IDLE, CORE_RST, DATA, PAD, ZERO, LEN_HI, LEN_LO, DRAIN, DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [3:0]     r_wcnt;
  logic [63:0]    r_bitcnt;
  logic           r_seen_busy;
  logic           r_core_nrst;
  logic [159:0]   r_digest;
  logic           r_digest_valid;

  logic           w_in_ready;
  logic           w_core_wr;
  logic [31:0]    w_core_in;
  logic [2:0]     w_add_bytes;
  logic [31:0]    w_masked;

  // Final partial word: keep the valid leading bytes, put 0x80 in the first
  // unused byte and zero the rest.
  always_comb begin
    w_masked = in_word;
    if (in_last) begin
      case (in_bytes)
        2'd1:    w_masked = {in_word[31:24], 8'h80, 16'h0000};
        2'd2:    w_masked = {in_word[31:16], 8'h80, 8'h00};
        2'd3:    w_masked = {in_word[31:8], 8'h80};
        default: w_masked = in_word;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_core_wr   = 1'b0;
    w_core_in   = 32'h0000_0000;
    w_add_bytes = 3'd0;
    case (r_state)
      IDLE: begin
        if (in_valid) w_next = CORE_RST;
      end
      CORE_RST: begin
        w_next = DATA;
      end
      DATA: begin
        w_in_ready = ~core_busy;
        if (in_valid && !core_busy) begin
          w_core_wr   = 1'b1;
          w_core_in   = w_masked;
          w_add_bytes = (in_last && in_bytes != 2'd0) ? {1'b0, in_bytes} : 3'd4;
          // A partial final word already carries the 0x80 byte.
          if (in_last) w_next = (in_bytes == 2'd0) ? PAD : ZERO;
        end
      end
      PAD: begin
        if (!core_busy) begin
          w_core_wr = 1'b1;
          w_core_in = 32'h8000_0000;
          w_next    = ZERO;
        end
      end
      ZERO: begin
        // Zero fill runs through index 15 and wraps into a fresh block when
        // the pad byte landed too late to leave room for the length.
        if (r_wcnt == 4'd14) begin
          w_next = LEN_HI;
        end else if (!core_busy) begin
          w_core_wr = 1'b1;
        end
      end
      LEN_HI: begin
        if (!core_busy) begin
          w_core_wr = 1'b1;
          w_core_in = r_bitcnt[63:32];
          w_next    = LEN_LO;
        end
      end
      LEN_LO: begin
        if (!core_busy) begin
          w_core_wr = 1'b1;
          w_core_in = r_bitcnt[31:0];
          w_next    = DRAIN;
        end
      end
      DRAIN: begin
        // The core must first pick up the final block (busy high) and then
        // finish it (busy low) before the chaining values are final.
        if (r_seen_busy && !core_busy) w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_wcnt         <= 4'd0;
      r_bitcnt       <= 64'd0;
      r_seen_busy    <= 1'b0;
      r_core_nrst    <= 1'b0;
      r_digest       <= 160'd0;
      r_digest_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_seen_busy <= (r_state == DRAIN) && (r_seen_busy || core_busy);
      // Registered so the core reset is glitch free; low exactly while in CORE_RST.
      r_core_nrst <= (w_next != CORE_RST);
      if (r_state == CORE_RST) begin
        r_wcnt   <= 4'd0;
        r_bitcnt <= 64'd0;
      end else begin
        if (w_core_wr) r_wcnt <= r_wcnt + 4'd1;
        if (r_state == DATA && w_core_wr)
          r_bitcnt <= r_bitcnt + {58'd0, w_add_bytes, 3'b000};
      end
      r_digest_valid <= (w_next == DONE);
      if (w_next == DONE) r_digest <= {core_h0, core_h1, core_h2, core_h3, core_h4};
    end
  end

  assign in_ready     = w_in_ready;
  assign core_wr      = w_core_wr;
  assign core_in      = w_core_in;
  assign core_nrst    = r_core_nrst;
  assign digest       = r_digest;
  assign digest_valid = r_digest_valid;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_sha1_msg_ctrl.sv
// Bench for sha1_msg_ctrl: a behavioural SHA-1 core answers the controller,
// and a reference built from standard SHA-1 padding of the byte message gives
// the expected core word stream and digest.
module tb_sha1_msg_ctrl;

  localparam logic [159:0] H_INIT  = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
  localparam logic [159:0] DIG_ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] DIG_56  = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_word;
  logic         in_last;
  logic [1:0]   in_bytes;
  logic         core_nrst;
  logic         core_wr;
  logic [31:0]  core_in;
  logic         core_busy;
  logic [31:0]  core_h0, core_h1, core_h2, core_h3, core_h4;
  logic [159:0] digest;
  logic         digest_valid;
  logic [3:0]   dbg_state;

  always #5 clk = ~clk;

  sha1_msg_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .in_last(in_last), .in_bytes(in_bytes),
    .core_nrst(core_nrst), .core_wr(core_wr), .core_in(core_in),
    .core_busy(core_busy),
    .core_h0(core_h0), .core_h1(core_h1), .core_h2(core_h2),
    .core_h3(core_h3), .core_h4(core_h4),
    .digest(digest), .digest_valid(digest_valid),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_wr = 0;
  int n_digest = 0;
  int dig_target = 0;
  logic [31:0]  exp_q[$];
  logic [159:0] exp_dig_q[$];
  logic [159:0] dig_hist[$];
  logic [31:0]  last1 = 0, last2 = 0;
  logic [7:0]   msg_q[$];
  bit           stall_en = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] sha1_comp(input logic [159:0] hin, input logic [511:0] blk);
    logic [31:0] w [0:79];
    logic [31:0] a, b, c, d, e, f, k, t, x;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      x = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {x[30:0], x[31]};
    end
    a = hin[159:128]; b = hin[127:96]; c = hin[95:64]; d = hin[63:32]; e = hin[31:0];
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
      else if (i < 40) begin f = b ^ c ^ d;                    k = 32'h6ed9eba1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d);  k = 32'h8f1bbcdc; end
      else             begin f = b ^ c ^ d;                    k = 32'hca62c1d6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
  endfunction

  // Standard SHA-1 padding of msg_q: expected core words and digest.
  task automatic build_expect();
    logic [7:0]   p[$];
    logic [63:0]  bl;
    logic [159:0] h;
    logic [511:0] b;
    logic [31:0]  wd;
    p  = msg_q;
    bl = 64'(msg_q.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    h = H_INIT;
    b = '0;
    for (int n = 0; n < p.size() / 64; n++) begin
      for (int j = 0; j < 16; j++) begin
        wd = {p[64*n+4*j], p[64*n+4*j+1], p[64*n+4*j+2], p[64*n+4*j+3]};
        exp_q.push_back(wd);
        b[511-32*j -: 32] = wd;
      end
      h = sha1_comp(h, b);
    end
    exp_dig_q.push_back(h);
    dig_target++;
  endtask

  // ---------------- core model + compare process ----------------
  logic [159:0] ch = H_INIT, hn = '0;
  logic [511:0] cblk = '0;
  int           widx = 0, cbusy = 0;
  logic         p_nrst = 1'b0, p_wr = 1'b0;
  logic [31:0]  p_in = '0;
  logic         prev_dv = 1'b0;
  int           lowrun = 0;
  bit           skip = 1;
  bit           stall;

  initial begin
    core_busy = 1'b0;
    {core_h0, core_h1, core_h2, core_h3, core_h4} = H_INIT;
  end

  always begin
    @(negedge clk);
    // Apply what the core saw at the previous rising edge.
    if (rst || !p_nrst) begin
      ch = H_INIT; widx = 0; cbusy = 0;
    end else if (p_wr) begin
      cblk[511-32*widx -: 32] = p_in;
      widx++;
      if (widx == 16) begin
        hn = sha1_comp(ch, cblk);
        widx = 0;
        cbusy = $urandom_range(2, 8);
      end
    end else if (cbusy > 0) begin
      cbusy--;
      if (cbusy == 0) ch = hn;
    end
    stall = stall_en && (cbusy == 0) && ($urandom_range(0, 99) < 25);
    core_busy = (cbusy > 0) || stall;
    {core_h0, core_h1, core_h2, core_h3, core_h4} = ch;
    #2;
    if (in_ready) chk("in_ready_while_busy", {159'd0, core_busy}, 160'd0);
    if (core_wr) begin
      n_wr++;
      last2 = last1;
      last1 = core_in;
      chk("core_wr_while_busy", {159'd0, core_busy}, 160'd0);
      chk("core_in", {128'd0, core_in}, (exp_q.size() > 0) ? {128'd0, exp_q.pop_front()} : 'x);
    end
    if (digest_valid) begin
      chk("digest_valid_pulse", {159'd0, prev_dv}, 160'd0);
      chk("digest", digest, (exp_dig_q.size() > 0) ? exp_dig_q.pop_front() : 'x);
      dig_hist.push_back(digest);
      n_digest++;
    end
    prev_dv = digest_valid;
    if (rst) begin
      lowrun = 0; skip = 1;
    end else if (skip) begin
      skip = 0;
    end else if (!core_nrst) begin
      lowrun++;
    end else begin
      if (lowrun > 0) chk("core_nrst_low_cycles", 160'(lowrun), 160'd1);
      lowrun = 0;
    end
    p_nrst = core_nrst;
    p_wr   = core_wr;
    p_in   = core_in;
  end

  // ---------------- driver tasks ----------------
  task automatic load_str(input string s, input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(s[i]);
  endtask

  task automatic load_rand(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic wait_digest();
    int budget = 0;
    while (n_digest < dig_target && budget < 5000) begin
      @(negedge clk);
      #3;
      budget++;
    end
    chk("digest_count", 160'(n_digest), 160'(dig_target));
  endtask

  // stop_after>0 sends only that many words without in_last.
  task automatic send_msg(input int stop_after, input bit gaps, input bit wait_dig);
    int len, nw, nsend, budget;
    logic [31:0] w;
    int idx;
    len = msg_q.size();
    nw = (len + 3) / 4;
    nsend = (stop_after > 0) ? stop_after : nw;
    build_expect();
    for (int i = 0; i < nsend; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      w = '0;
      for (int b = 0; b < 4; b++) begin
        idx = 4*i + b;
        w = {w[23:0], (idx < len) ? msg_q[idx] : 8'($urandom_range(0, 255))};
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_word  = w;
      in_last  = (stop_after == 0) && (i == nw - 1);
      in_bytes = in_last ? 2'(len % 4) : 2'($urandom_range(0, 3));
      #2;
      budget = 0;
      while (!in_ready && budget < 2000) begin
        @(negedge clk);
        #2;
        budget++;
      end
      if (!in_ready) chk("word_accept_timeout", 160'(budget), 160'd0);
    end
    if (wait_dig) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      wait_digest();
    end
  endtask

  // ---------------- stimulus ----------------
  int w0;
  string s56;

  initial begin
    s56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    rst = 1'b1; in_valid = 1'b0; in_word = '0; in_last = 1'b0; in_bytes = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_in_ready",     {159'd0, in_ready}, 160'd0);
    chk("rst_core_wr",      {159'd0, core_wr}, 160'd0);
    chk("rst_core_in",      {128'd0, core_in}, 160'd0);
    chk("rst_core_nrst",    {159'd0, core_nrst}, 160'd0);
    chk("rst_digest",       digest, 160'd0);
    chk("rst_digest_valid", {159'd0, digest_valid}, 160'd0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    // "abc"
    load_str("abc", 3);
    w0 = n_wr;
    send_msg(0, 0, 1);
    chk("abc_digest", dig_hist[$], DIG_ABC);
    chk("abc_writes", 160'(n_wr - w0), 160'd16);
    chk("abc_word14", {128'd0, last2}, 160'h0);
    chk("abc_word15", {128'd0, last1}, 160'h18);

    // 56 bytes: padding spills into a second block
    load_str(s56, 56);
    w0 = n_wr;
    send_msg(0, 0, 1);
    chk("m56_digest", dig_hist[$], DIG_56);
    chk("m56_writes", 160'(n_wr - w0), 160'd32);

    // 55 bytes: pad byte fits in word 13, single block
    load_str(s56, 55);
    w0 = n_wr;
    send_msg(0, 0, 1);
    chk("m55_writes", 160'(n_wr - w0), 160'd16);
    chk("m55_len_word", {128'd0, last1}, 160'h1b8);

    // Reset after 5 words, then "abc"
    stall_en = 1;
    load_rand(40);
    send_msg(5, 1, 0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    exp_q.delete();
    exp_dig_q.delete();
    repeat (2) @(negedge clk);
    #2;
    chk("midrst_digest_cleared", digest, 160'd0);
    @(negedge clk); rst = 1'b0;
    dig_target = n_digest;
    repeat (2) @(negedge clk);
    load_str("abc", 3);
    send_msg(0, 1, 1);
    chk("after_rst_abc_digest", dig_hist[$], DIG_ABC);

    // Back-to-back "abc"; the second message is offered before the first ends
    load_str("abc", 3);
    send_msg(0, 0, 0);
    send_msg(0, 0, 1);
    chk("b2b_first",  dig_hist[dig_hist.size()-2], DIG_ABC);
    chk("b2b_second", dig_hist[$], DIG_ABC);

    // Random lengths with input gaps and core stalls
    for (int m = 0; m < 12; m++) begin
      load_rand($urandom_range(1, 150));
      send_msg(0, 1, 1);
    end
    chk("scoreboard_drained", 160'(exp_q.size()), 160'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sha1_msg_ctrl.md
SHA1_MSG_CTRL -- requirements
Module: sha1_msg_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: in_valid  in  1  message word offered; in_ready  out  1  word accepted when in_valid&in_ready.
REQ-004 SHALL have: in_word  in  32  message word, big-endian (byte 0 = bits 31:24).
REQ-005 SHALL have: in_last  in  1  final message word; in_bytes  in  2  valid bytes in final word (0=4, 1..3 literal), ignored unless in_last.
REQ-006 SHALL have: core_nrst  out  1  active-low reset to sha1 core; core_wr  out  1; core_in  out  32  word to core.
REQ-007 SHALL have: core_busy  in  1; core_h0..core_h4  in  32 each  core chaining values.
REQ-008 SHALL have: digest  out  160  {h0,h1,h2,h3,h4}; digest_valid  out  1  one-cycle pulse.

Function
REQ-009 SHALL accept messages of 1 byte or more, word-granular; empty messages are not supported.
REQ-010 SHALL assert core_nrst low for exactly one cycle (state CORE_RST) before the first word of every message, so the core reloads initial H values.
REQ-011 SHALL use states IDLE, CORE_RST, DATA, PAD, ZERO, LEN_HI, LEN_LO, DRAIN, DONE.
REQ-012 IDLE: in_ready=0; on in_valid go to CORE_RST. CORE_RST -> DATA next cycle.
REQ-013 core_wr SHALL be asserted only when core_busy=0; in DATA, in_ready = ~core_busy, and core_wr = in_valid&in_ready with core_in=in_word, except that a final word with in_bytes!=0 is masked: unused bytes zero, first unused byte = 0x80.
REQ-014 A 4-bit word counter wcnt SHALL increment on every core_wr and wrap 15->0; a 64-bit bit counter SHALL add 8*bytes per accepted word (modulo 2^64).
REQ-015 On final word: in_bytes=0 -> PAD (writes 0x80000000); else -> ZERO directly (0x80 already inserted).
REQ-016 ZERO SHALL write 0x00000000 while wcnt!=14; at wcnt==14 -> LEN_HI; wcnt 15 in ZERO writes zero and wraps, continuing into a new block.
REQ-017 Transitions SHALL be decided on wcnt after the pad byte: if the 0x80 word lands at index 14 or 15, padding SHALL spill into a second block (zeros to index 13 of next block).
REQ-018 LEN_HI writes bitcount[63:32]; LEN_LO writes bitcount[31:0] (wcnt==15) -> DRAIN.
REQ-019 DRAIN SHALL wait for core_busy to be seen high, then low; then -> DONE.
REQ-020 DONE: digest={core_h0..core_h4} registered, digest_valid=1 for one cycle, -> IDLE; digest holds until next DONE.
REQ-021 Core writes in PAD/ZERO/LEN states SHALL stall (no state/counter change) while core_busy=1.
REQ-022 in_valid during non-DATA states SHALL be ignored (in_ready=0); a new message may start the cycle after DONE.

Reset
REQ-023 rst high SHALL force state IDLE, wcnt=0, bitcount=0, digest=0, digest_valid=0, in_ready=0, core_wr=0, core_in=0, core_nrst=0 asynchronously.
REQ-024 core_nrst SHALL be ~rst & (state!=CORE_RST), registered-free of glitches (driven from a flop).
REQ-025 rst mid-message SHALL abandon the message; next message after release SHALL hash correctly.

Verification
REQ-026 "abc": one word 0x61626300, in_last, in_bytes=3 -> digest a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d, 16 core writes, last two 0x00000000/0x00000018.
REQ-027 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (14 words, in_bytes=0) -> 32 core writes, digest 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
REQ-028 55-byte message (in_bytes=3 on word 14) -> exactly 16 core writes, length word 0x000001b8.
REQ-029 Random in_valid gaps plus core_busy stalls -> in_ready never high with core_busy high; digest matches reference model.
REQ-030 rst pulse after 5 words of a message, then "abc" -> digest a9993e36...9cd0d89d; back-to-back "abc" twice -> two identical digest_valid pulses.
